// File: rtl/divu_unit.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// quotient on lo, remainder on hi, one-cycle done pulse.
module divu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             last_iter;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    // Trial subtraction is one bit wider than the remainder so the borrow is kept.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (b == '0) ? FIX : RUN;
            RUN:  if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == FIX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        cnt   <= '0;
                        dvs   <= mag(b, sgn);
                        q_neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg <= sgn && a[WIDTH-1];
                        // On divide-by-zero the raw dividend is parked in quo for hi.
                        dz    <= (b == '0);
                        quo   <= (b == '0) ? a : mag(a, sgn);
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                end
                FIX: begin
                    div_zero <= dz;
                    lo       <= dz ? '1  : (q_neg ? neg(quo) : quo);
                    hi       <= dz ? quo : (r_neg ? neg(rem) : rem);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_unit.sv
// Self-checking bench for divu_unit: scoreboard of expected results, one task per scenario.
module tb_divu_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    divu_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy;
        e.dz = 1'b0;
        if (y == 0) begin
            e.lo = '1; e.hi = x; e.dz = 1'b1;
        end else if (!s) begin
            e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.lo = x; e.hi = '0;
        end else begin
            sx = x; sy = y;
            e.lo = sx / sy; e.hi = sx % sy;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] l, input logic [W-1:0] h, input logic d);
        exp_t e;
        e.lo = l; e.hi = h; e.dz = d;
        return e;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after E0.
    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; sgn = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges from E0 until done is seen; flags any cycle before done with busy low.
    task automatic wait_done(input int limit, output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (lat < limit) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat; bit bok; exp_t e;
        sb.push_back(mk(32'd14, 32'd2, 1'b0));
        issue(1'b0, 32'd100, 32'd7);
        wait_done(40, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL unsigned_latency: got %0d want 33", lat); end
        n_cmp++; if (!bok) begin n_bad++; $display("FAIL unsigned_busy_run: got busy low want high"); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL unsigned_busy_done: got %b want 0", busy); end
        n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL unsigned_lo: got %h want %h", lo, e.lo); end
        n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL unsigned_hi: got %h want %h", hi, e.hi); end
        n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL unsigned_dz: got %b want %b", div_zero, e.dz); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_table(input string name, input logic s, input logic [W-1:0] xs[],
                              input logic [W-1:0] ys[], input logic [W-1:0] ql[], input logic [W-1:0] rh[]);
        int lat; bit bok; exp_t e;
        for (int i = 0; i < xs.size(); i++) begin
            sb.push_back(mk(ql[i], rh[i], 1'b0));
            issue(s, xs[i], ys[i]);
            wait_done(40, lat, bok);
            e = sb.pop_front();
            n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL %s_%0d_latency: got %0d want 33", name, i, lat); end
            n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL %s_%0d_lo: got %h want %h", name, i, lo, e.lo); end
            n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL %s_%0d_hi: got %h want %h", name, i, hi, e.hi); end
            n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL %s_%0d_dz: got %b want 0", name, i, div_zero); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] xs[] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] ys[] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        logic [W-1:0] ql[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd3, 32'h8000_0000};
        logic [W-1:0] rh[] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0};
        test_table("signed", 1'b1, xs, ys, ql, rh);
    endtask

    task automatic test_edge();
        logic [W-1:0] xs[] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        logic [W-1:0] ys[] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] ql[] = '{32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] rh[] = '{32'd0, 32'd5, 32'h8000_0000};
        test_table("edge", 1'b0, xs, ys, ql, rh);
    endtask

    task automatic test_div_zero();
        int lat; bit bok; exp_t e;
        sb.push_back(mk(32'hFFFF_FFFF, 32'h1234, 1'b1));
        issue(1'b0, 32'h1234, 32'd0);
        wait_done(5, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++; if (!bok) begin n_bad++; $display("FAIL dz_busy: got busy low want high after E0"); end
        n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL dz_lo: got %h want %h", lo, e.lo); end
        n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL dz_hi: got %h want %h", hi, e.hi); end
        n_cmp++; if (div_zero !== e.dz) begin n_bad++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_held: got %b want 1", div_zero); end
        sb.push_back(mk(32'd3, 32'd1, 1'b0));
        issue(1'b0, 32'd10, 32'd3);
        wait_done(40, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL dz_next_latency: got %0d want 33", lat); end
        n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_bad++; $display("FAIL dz_next_result: got %h/%h want %h/%h", lo, hi, e.lo, e.hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_cleared: got %b want 0", div_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int lat; bit bok; int extra; exp_t e;
        sb.push_back(mk(32'd14, 32'd2, 1'b0));
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        issue(1'b1, 32'hFFFF_FFCE, 32'd3);
        wait_done(30, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lat + 10 !== 33) begin n_bad++; $display("FAIL ignore_latency: got %0d want 33", lat + 10); end
        n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_bad++; $display("FAIL ignore_result: got %h/%h want %h/%h", lo, hi, e.lo, e.hi); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_no_second: got %0d extra done want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; bit held; exp_t e;
        sb.push_back(mk(32'd100, 32'd0, 1'b0));
        issue(1'b0, 32'd1000, 32'd10);
        wait_done(40, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_bad++; $display("FAIL b2b_first: got %h/%h want %h/%h", lo, hi, e.lo, e.hi); end
        sb.push_back(mk(32'd15, 32'd2, 1'b0));
        issue(1'b0, 32'd77, 32'd5);
        lat = 0; held = 1'b1;
        while (lat < 40) begin
            if (lo !== 32'd100 || hi !== 32'd0) held = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
        e = sb.pop_front();
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        n_cmp++; if (!held) begin n_bad++; $display("FAIL b2b_held: old result not held until new done"); end
        n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_bad++; $display("FAIL b2b_second: got %h/%h want %h/%h", lo, hi, e.lo, e.hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; int seen; exp_t e;
        issue(1'b0, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, div_zero, lo, hi} !== '0) begin n_bad++;
            $display("FAIL midreset_outputs: got busy=%b done=%b dz=%b lo=%h hi=%h want all 0", busy, done, div_zero, lo, hi); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
        sb.push_back(mk(32'd3, 32'd1, 1'b0));
        issue(1'b0, 32'd10, 32'd3);
        wait_done(40, lat, bok);
        e = sb.pop_front();
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL midreset_next_latency: got %0d want 33", lat); end
        n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_bad++; $display("FAIL midreset_next_result: got %h/%h want %h/%h", lo, hi, e.lo, e.hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit bok; exp_t e; logic s; logic [W-1:0] x, y;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = (i % 3 == 0) ? W'($urandom_range(1, 50)) : W'($urandom);
            if (i % 4 == 1) y = -y;
            sb.push_back(model(s, x, y));
            issue(s, x, y);
            wait_done(40, lat, bok);
            e = sb.pop_front();
            n_cmp++; if (lo !== e.lo || hi !== e.hi || div_zero !== e.dz) begin n_bad++;
                $display("FAIL random_%0d: sgn=%b a=%h b=%h got %h/%h/%b want %h/%h/%b", i, s, x, y, lo, hi, div_zero, e.lo, e.hi, e.dz); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_edge();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
